// File: rtl/reg_file_scoreboard.sv
// Windowed two-read/one-write register file with write-to-read bypass
// and a per-register busy scoreboard for decode hazard detection.
module reg_file_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int BASE_ADDR = 0,
  parameter int ZERO_REG  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAddrA,
  output logic [DATA_W-1:0] readDataA,
  output logic              busyA,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic [DATA_W-1:0] readDataB,
  output logic              busyB,
  input  logic              reserveEn,
  input  logic [ADDR_W-1:0] reserveAddress,
  output logic              addrError
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] LO =
    (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] HI =
    (ADDR_W+1)'(BASE_ADDR + NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busyBits;
  logic [NUM_REGS-1:0] busyNext;
  logic                writeOk;
  logic                reserveOk;
  logic                writeBad;
  logic                reserveBad;
  logic [IDX_W-1:0]    wIdx;
  logic [IDX_W-1:0]    rIdx;
  logic [DATA_W:0]     portA;
  logic [DATA_W:0]     portB;

  // Extra top bit keeps the window compare free of wrap-around.
  function automatic logic inWin(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W:0] e;
    e = {1'b0, a};
    return (e >= LO) && (e < HI);
  endfunction

  function automatic logic live(
    input logic [ADDR_W-1:0] a
  );
    logic isZero;
    isZero = (ZERO_REG == 1) && (a == '0);
    return inWin(a) && !isZero;
  endfunction

  function automatic logic [IDX_W-1:0] toIdx(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W:0] d;
    d = {1'b0, a} - LO;
    return d[IDX_W-1:0];
  endfunction

  assign writeOk    = regWrite && live(writeAddress);
  assign reserveOk  = reserveEn && live(reserveAddress);
  assign writeBad   = regWrite && !inWin(writeAddress);
  assign reserveBad = reserveEn && !inWin(reserveAddress);
  assign wIdx       = toIdx(writeAddress);
  assign rIdx       = toIdx(reserveAddress);

  // Returns {busy, data} for one read port.
  function automatic logic [DATA_W:0] rdPort(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W:0] r;
    logic            hit;
    logic            rsv;
    hit = writeOk && (writeAddress == a);
    rsv = reserveOk && (reserveAddress == a);
    r   = '0;
    unique case (1'b1)
      !live(a): r = '0;
      hit:      r = {rsv, writeData};
      default:  r = {busyBits[toIdx(a)],
                     regs[toIdx(a)]};
    endcase
    return r;
  endfunction

  always_comb begin
    portA = rdPort(readAddrA);
    portB = rdPort(readAddrB);
  end

  assign readDataA = portA[DATA_W-1:0];
  assign busyA     = portA[DATA_W];
  assign readDataB = portB[DATA_W-1:0];
  assign busyB     = portB[DATA_W];

  // A new reservation overrides the completing write.
  always_comb begin
    busyNext = busyBits;
    if (writeOk)
      busyNext[wIdx] = 1'b0;
    if (reserveOk)
      busyNext[rIdx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busyBits  <= '0;
      addrError <= 1'b0;
    end else begin
      if (writeOk)
        regs[wIdx] <= writeData;
      busyBits <= busyNext;
      if (writeBad || reserveBad)
        addrError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Random and directed bench for reg_file_scoreboard, checking a full
// window and a BASE_ADDR=8/NUM_REGS=16 window against a model.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        regWrite = 1'b0;
  logic [4:0]  writeAddress = '0;
  logic [31:0] writeData = '0;
  logic [4:0]  readAddrA = '0;
  logic [4:0]  readAddrB = '0;
  logic        reserveEn = 1'b0;
  logic [4:0]  reserveAddress = '0;

  logic [31:0] rdA [2];
  logic [31:0] rdB [2];
  logic        bA  [2];
  logic        bB  [2];
  logic        err [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mReg  [2][32];
  bit          mBusy [2][32];
  bit          mErr  [2];
  int          mBase [2] = '{0, 8};
  int          mNum  [2] = '{32, 16};

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk(clk), .reset(reset),
    .regWrite(regWrite),
    .writeAddress(writeAddress),
    .writeData(writeData),
    .readAddrA(readAddrA),
    .readDataA(rdA[0]), .busyA(bA[0]),
    .readAddrB(readAddrB),
    .readDataB(rdB[0]), .busyB(bB[0]),
    .reserveEn(reserveEn),
    .reserveAddress(reserveAddress),
    .addrError(err[0])
  );

  reg_file_scoreboard #(
    .BASE_ADDR(8), .NUM_REGS(16)
  ) dutWin (
    .clk(clk), .reset(reset),
    .regWrite(regWrite),
    .writeAddress(writeAddress),
    .writeData(writeData),
    .readAddrA(readAddrA),
    .readDataA(rdA[1]), .busyA(bA[1]),
    .readAddrB(readAddrB),
    .readDataB(rdB[1]), .busyB(bB[1]),
    .reserveEn(reserveEn),
    .reserveAddress(reserveAddress),
    .addrError(err[1])
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit mValid(int i, logic [4:0] a);
    return int'(a) >= mBase[i] &&
           int'(a) < mBase[i] + mNum[i];
  endfunction

  function automatic bit mLive(int i, logic [4:0] a);
    return mValid(i, a) && a != 5'd0;
  endfunction

  function automatic logic [31:0] expData(
    int i, logic [4:0] a
  );
    if (!mLive(i, a)) return 32'h0;
    if (regWrite && writeAddress == a) return writeData;
    return mReg[i][int'(a) - mBase[i]];
  endfunction

  function automatic logic expBusy(int i, logic [4:0] a);
    if (!mLive(i, a)) return 1'b0;
    if (regWrite && writeAddress == a)
      return reserveEn && reserveAddress == a;
    return mBusy[i][int'(a) - mBase[i]];
  endfunction

  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) begin
          mReg[i][r]  = '0;
          mBusy[i][r] = 1'b0;
        end
        mErr[i] = 1'b0;
      end else begin
        if (regWrite && !mValid(i, writeAddress))
          mErr[i] = 1'b1;
        if (reserveEn && !mValid(i, reserveAddress))
          mErr[i] = 1'b1;
        if (regWrite && mLive(i, writeAddress)) begin
          mReg[i][int'(writeAddress) - mBase[i]] = writeData;
          mBusy[i][int'(writeAddress) - mBase[i]] = 1'b0;
        end
        if (reserveEn && mLive(i, reserveAddress))
          mBusy[i][int'(reserveAddress) - mBase[i]] = 1'b1;
      end
    end
  endtask

  task automatic drive(
    input bit          rst,
    input bit          we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic [4:0]  ra,
    input logic [4:0]  rb,
    input bit          re,
    input logic [4:0]  rs,
    input bit          chk
  );
    reset = rst;
    regWrite = we;
    writeAddress = wa;
    writeData = wd;
    readAddrA = ra;
    readAddrB = rb;
    reserveEn = re;
    reserveAddress = rs;
    #1;
    if (chk)
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rdA%0d", i), rdA[i], expData(i, ra));
        check($sformatf("rdB%0d", i), rdB[i], expData(i, rb));
        check($sformatf("bA%0d", i), 32'(bA[i]),
              32'(expBusy(i, ra)));
        check($sformatf("bB%0d", i), 32'(bB[i]),
              32'(expBusy(i, rb)));
        check($sformatf("err%0d", i), 32'(err[i]),
              32'(mErr[i]));
      end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] ra, input logic [4:0] rb);
    drive(0, 0, 0, 0, ra, rb, 0, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1);
    tick();
    rd(5, 0);
    check("rstData", rdA[0], 32'h0);
    check("rstBusy", 32'(bA[0]), 32'h0);
    check("rstErr", 32'(err[0]), 32'h0);
    tick();

    drive(0, 1, 9, 32'h12345678, 0, 9, 0, 0, 1);
    check("bypassB", rdB[0], 32'h12345678);
    tick();
    rd(0, 9);
    check("heldB", rdB[0], 32'h12345678);
    tick();

    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    check("zeroByp", rdA[0], 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("zeroRd", rdA[0], 32'h0);
    tick();
    rd(0, 0);
    check("zeroBusy", 32'(bA[0]), 32'h0);
    tick();

    drive(0, 0, 0, 0, 17, 0, 1, 17, 1);
    tick();
    rd(17, 0);
    check("rsvBusy", 32'(bA[0]), 32'h1);
    tick();
    drive(0, 1, 17, 32'hA5A5A5A5, 17, 0, 0, 0, 1);
    check("wrBusyByp", 32'(bA[0]), 32'h0);
    check("wrDataByp", rdA[0], 32'hA5A5A5A5);
    tick();
    rd(17, 0);
    check("wrBusyAfter", 32'(bA[0]), 32'h0);
    tick();
    drive(0, 1, 17, 32'h1, 17, 0, 1, 17, 1);
    check("bothBusyByp", 32'(bA[0]), 32'h1);
    tick();
    rd(17, 0);
    check("bothBusy", 32'(bA[0]), 32'h1);
    tick();

    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 1, 23, 32'h1, 0, 0, 0, 0, 1);
    tick();
    rd(23, 0);
    check("win23", rdA[1], 32'h1);
    check("winErr0", 32'(err[1]), 32'h0);
    tick();
    drive(0, 1, 24, 32'hBAD, 0, 0, 0, 0, 1);
    tick();
    rd(0, 24);
    check("winErr24", 32'(err[1]), 32'h1);
    check("win24", rdB[1], 32'h0);
    tick();
    drive(1'b0, 1'b1, 5'd7, 32'hBAD7, 0, 0, 0, 0, 1);
    tick();
    rd(7, 23);
    check("win7", rdA[1], 32'h0);
    check("winErrSticky", 32'(err[1]), 32'h1);
    check("win23kept", rdB[1], 32'h1);
    tick();

    drive(0, 1, 10, 32'h55, 0, 0, 0, 0, 1);
    tick();
    rd(10, 10);
    check("dualA", rdA[0], 32'h55);
    check("dualB", rdB[0], 32'h55);
    tick();
    drive(0, 0, 0, 0, 10, 10, 1, 10, 1);
    tick();
    drive(1, 0, 0, 0, 10, 10, 0, 0, 1);
    check("preRstBusyB", 32'(bB[0]), 32'h1);
    tick();
    rd(10, 10);
    check("postRstBusyA", 32'(bA[0]), 32'h0);
    check("postRstBusyB", 32'(bB[0]), 32'h0);
    check("postRstData", rdA[0], 32'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa, rs, ra, rb;
      wa = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 3) == 0) ? wa :
           5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? wa :
           5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? rs :
           5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 1)), wa, $urandom,
            ra, rb, 1'($urandom_range(0, 1)), rs, 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
